// File: rtl/sdram_mock_pkg.sv
// Shared definitions for the SDRAM mock responder: command encodings, FSM states
// and the helpers that compute wrapped burst addresses and saturating counts.
package sdram_mock_pkg;

    // Widest address the burst helper handles; ADDR_W must not exceed this.
    localparam int ADDR_MAX_W = 32;

    // Strobe encodings, ordered {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] ENC_READ  = 4'b0001;
    localparam logic [3:0] ENC_WRITE = 4'b0000;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_READ,
        CMD_WRITE
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_LAT,
        ST_RD_BURST,
        ST_WR_BURST
    } state_e;

    function automatic cmd_e decode_cmd(
        input logic cs_n,
        input logic ras_n,
        input logic cas_n,
        input logic we_n
    );
        case ({cs_n, ras_n, cas_n, we_n})
            ENC_READ:  return CMD_READ;
            ENC_WRITE: return CMD_WRITE;
            default:   return CMD_NOP;
        endcase
    endfunction

    // Word 'beat' of a burst wraps inside the BURST_LEN-aligned block holding 'base'.
    function automatic logic [ADDR_MAX_W-1:0] burst_addr(
        input logic [ADDR_MAX_W-1:0] base,
        input logic [ADDR_MAX_W-1:0] beat,
        input int unsigned           blen
    );
        logic [ADDR_MAX_W-1:0] mask;
        mask = ADDR_MAX_W'(blen - 1);
        return (base & ~mask) | ((base + beat) & mask);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/sdram_mock_array.sv
// Word storage for the SDRAM mock: one asynchronous read port and one write port
// whose burst data yields to the backdoor load when both target the same word.
module sdram_mock_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 1048576
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_take;
    logic              ld_take;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_EXT;
    endfunction

    assign ld_take = ld_en && in_range(ld_addr);
    assign wr_take = wr_en && in_range(wr_addr) && !(ld_en && (ld_addr == wr_addr));

    // NOTE: the storage array has no reset branch; contents must survive reset and a
    // reset loop over a deep memory would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (wr_take) begin
            mem_q[IDX_W'(wr_addr)] <= wr_data;
        end
        if (ld_take) begin
            mem_q[IDX_W'(ld_addr)] <= ld_data;
        end
    end

    // Asynchronous read so a word written on the previous edge is returned at once.
    assign rd_data = in_range(rd_addr) ? mem_q[IDX_W'(rd_addr)] : '0;

endmodule

// File: rtl/sdram_mock_responder.sv
// Behavioural SDRAM target: decodes READ/WRITE strobes, returns CAS-delayed wrapped
// read bursts on a tri-state bus, accepts write bursts and counts completed bursts.
module sdram_mock_responder
    import sdram_mock_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 20,
    parameter int unsigned       DEPTH     = 1048576,
    parameter int unsigned       CAS_LAT   = 2,
    parameter int unsigned       BURST_LEN = 4,
    parameter logic [DATA_W-1:0] FILL      = '1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_data,
    input  logic              sdram_we_n,
    input  logic              sdram_cs_n,
    input  logic              sdram_ras_n,
    input  logic              sdram_cas_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              cmd_err,
    output logic              oob_err
);

    localparam int unsigned     BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned     LAT_W     = 3;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [BEAT_W-1:0] beat_q;
    logic [LAT_W-1:0]  lat_q;
    logic [15:0]       rd_count_q;
    logic [15:0]       wr_count_q;
    logic              cmd_err_q;
    logic              oob_err_q;

    cmd_e              cmd;
    logic [ADDR_W-1:0] beat_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_oob;
    logic              wr_beat;
    logic              rd_beat;
    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_rd_data;
    logic [DATA_W-1:0] rd_word;

    assign cmd = decode_cmd(sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n);

    // NOTE: every signal written here gets a value before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        beat_addr = ADDR_W'(burst_addr(ADDR_MAX_W'(base_q), ADDR_MAX_W'(beat_q), BURST_LEN));
        cur_addr  = beat_addr;
        if (state_q == ST_IDLE) begin
            cur_addr = sdram_addr;
        end
        cur_oob   = ({1'b0, cur_addr} >= DEPTH_EXT);
        wr_beat   = (state_q == ST_WR_BURST) || (state_q == ST_IDLE && cmd == CMD_WRITE);
        rd_beat   = (state_q == ST_RD_BURST);
        arr_wr_en = wr_beat && !cur_oob;
    end

    sdram_mock_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_addr (cur_addr),
        .wr_data (sdram_data),
        .ld_en   (load_en),
        .ld_addr (load_addr),
        .ld_data (load_data),
        .rd_addr (cur_addr),
        .rd_data (arr_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            cmd_err_q  <= 1'b0;
            oob_err_q  <= 1'b0;
        end else begin
            if (state_q != ST_IDLE && cmd != CMD_NOP) begin
                cmd_err_q <= 1'b1;
            end
            if ((wr_beat || rd_beat) && cur_oob) begin
                oob_err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    beat_q <= '0;
                    lat_q  <= '0;
                    if (cmd == CMD_READ) begin
                        base_q  <= sdram_addr;
                        state_q <= (CAS_LAT == 1) ? ST_RD_BURST : ST_RD_LAT;
                    end else if (cmd == CMD_WRITE) begin
                        base_q <= sdram_addr;
                        // Word 0 is written in the command cycle itself.
                        if (BURST_LEN == 1) begin
                            wr_count_q <= sat_inc(wr_count_q);
                        end else begin
                            beat_q  <= BEAT_W'(1);
                            state_q <= ST_WR_BURST;
                        end
                    end
                end

                ST_RD_LAT: begin
                    if (lat_q == LAT_W'(CAS_LAT - 2)) begin
                        lat_q   <= '0;
                        state_q <= ST_RD_BURST;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end

                ST_RD_BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        beat_q     <= '0;
                        rd_count_q <= sat_inc(rd_count_q);
                        state_q    <= ST_IDLE;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end

                ST_WR_BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        beat_q     <= '0;
                        wr_count_q <= sat_inc(wr_count_q);
                        state_q    <= ST_IDLE;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_word    = cur_oob ? FILL : arr_rd_data;
    assign sdram_data = rd_valid ? rd_word : 'z;

    assign rd_valid = (state_q == ST_RD_BURST);
    assign busy     = (state_q != ST_IDLE);
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign cmd_err  = cmd_err_q;
    assign oob_err  = oob_err_q;

endmodule

// File: tb/tb_sdram_mock_responder.sv
// Self-checking bench for sdram_mock_responder: a table of read/write bursts plus
// hand-written sequences for collisions, reset aborts and read-after-write.
module tb_sdram_mock_responder;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 20;
    localparam int DEPTH     = 256;
    localparam int CAS_LAT   = 2;
    localparam int BURST_LEN = 4;
    localparam logic [DATA_W-1:0] FILL = '1;

    typedef logic [BURST_LEN-1:0][DATA_W-1:0] burst_t;
    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        burst_t            d;
        bit                exp_oob;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] sdram_addr;
    wire  [DATA_W-1:0] sdram_data;
    logic              sdram_we_n, sdram_cs_n, sdram_ras_n, sdram_cas_n;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              rd_valid, busy, cmd_err, oob_err;
    logic [15:0]       rd_count, wr_count;

    logic              bus_en;
    logic [DATA_W-1:0] bus_d;
    assign sdram_data = bus_en ? bus_d : 'z;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                exp_rd   = 0;
    int                exp_wr   = 0;
    logic [DATA_W-1:0] sb [$];
    vec_t              vecs [9];

    always #5 clk = ~clk;

    sdram_mock_responder #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .CAS_LAT   (CAS_LAT),
        .BURST_LEN (BURST_LEN),
        .FILL      (FILL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sdram_addr  (sdram_addr),
        .sdram_data  (sdram_data),
        .sdram_we_n  (sdram_we_n),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .cmd_err     (cmd_err),
        .oob_err     (oob_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic burst_t mk_burst(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                                        input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3);
        burst_t b;
        b[0] = w0; b[1] = w1; b[2] = w2; b[3] = w3;
        return b;
    endfunction

    function automatic vec_t mk_vec(input bit wr, input logic [ADDR_W-1:0] addr,
                                    input burst_t d, input bit exp_oob);
        vec_t v;
        v.wr = wr; v.addr = addr; v.d = d; v.exp_oob = exp_oob;
        return v;
    endfunction

    task automatic set_cmd(input bit active, input bit wr, input logic [ADDR_W-1:0] addr);
        sdram_cs_n  = !active;
        sdram_ras_n = !active;
        sdram_cas_n = !active;
        sdram_we_n  = !(active && wr);
        sdram_addr  = addr;
    endtask

    task automatic load(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        load_en = 1'b1; load_addr = addr; load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        sb.delete();
        exp_rd = 0;
        exp_wr = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    // Drives one command; reads push their expected words, writes stream their data.
    task automatic issue(input bit wr, input logic [ADDR_W-1:0] addr, input burst_t d);
        set_cmd(1'b1, wr, addr);
        if (wr) begin
            bus_en = 1'b1;
            bus_d  = d[0];
        end else begin
            for (int k = 0; k < BURST_LEN; k++) sb.push_back(d[k]);
        end
        tick();
        set_cmd(1'b0, 1'b0, '0);
        if (wr) begin
            for (int k = 1; k < BURST_LEN; k++) begin
                bus_d = d[k];
                check("wr_bus_not_driven", rd_valid, 0);
                tick();
            end
            bus_en = 1'b0;
            exp_wr++;
        end
    endtask

    // Collects one read burst; n0 is the cycle index after the command cycle.
    task automatic drain_read(input string tag, input int n0);
        int seen = 0;
        bit done = 0;
        for (int n = n0; n <= n0 + 20 && !done; n++) begin
            if (rd_valid) begin
                if (seen == 0) check({tag, "_latency"}, n, CAS_LAT);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_extra_word: got %h, expected no word", tag, sdram_data);
                end else begin
                    check({tag, "_word"}, sdram_data, sb.pop_front());
                end
                seen++;
            end else if (seen > 0) begin
                done = 1;
            end
            if (!done) tick();
        end
        check({tag, "_beats"}, seen, BURST_LEN);
        check({tag, "_idle"}, busy, 0);
        exp_rd++;
    endtask

    initial begin
        burst_t b10;
        reset_n = 1'b0;
        bus_en = 1'b0; bus_d = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        set_cmd(1'b0, 1'b0, '0);
        apply_reset();

        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_oob_err", oob_err, 0);

        for (int i = 0; i < 4; i++) load(ADDR_W'(i), 32'h1000_0000 + i);
        load('h10, 32'hA5A5_A5A5);
        load('h11, 32'h1111_1111);
        load('h12, 32'h2222_2222);
        load('h13, 32'h3333_3333);
        for (int i = 'hFC; i <= 'hFF; i++) load(ADDR_W'(i), 32'hC0DE_0000 + i);

        b10 = mk_burst(32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        vecs[0] = mk_vec(0, 'h010, b10, 0);
        vecs[1] = mk_vec(1, 'h00E, mk_burst(1, 2, 3, 4), 0);
        vecs[2] = mk_vec(0, 'h00E, mk_burst(1, 2, 3, 4), 0);
        vecs[3] = mk_vec(0, 'h00C, mk_burst(3, 4, 1, 2), 0);
        vecs[4] = mk_vec(0, 'h012, mk_burst(32'h2222_2222, 32'h3333_3333, 32'hA5A5_A5A5, 32'h1111_1111), 0);
        vecs[5] = mk_vec(0, 'h0FF, mk_burst(32'hC0DE_00FF, 32'hC0DE_00FC, 32'hC0DE_00FD, 32'hC0DE_00FE), 0);
        vecs[6] = mk_vec(0, ADDR_W'(DEPTH), mk_burst(FILL, FILL, FILL, FILL), 1);
        vecs[7] = mk_vec(1, ADDR_W'(DEPTH + 1), mk_burst(32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0003, 32'hBAD0_0000), 1);
        vecs[8] = mk_vec(0, 'h000, mk_burst(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003), 1);

        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            issue(vecs[i].wr, vecs[i].addr, vecs[i].d);
            if (!vecs[i].wr) drain_read(tag, 1);
            check({tag, "_rd_count"}, rd_count, exp_rd);
            check({tag, "_wr_count"}, wr_count, exp_wr);
            check({tag, "_oob_err"}, oob_err, vecs[i].exp_oob);
            check({tag, "_cmd_err"}, cmd_err, 0);
        end

        // A READ during the latency phase is ignored and flagged.
        apply_reset();
        issue(0, 'h10, b10);
        set_cmd(1'b1, 1'b0, 'h0E);
        tick();
        set_cmd(1'b0, 1'b0, '0);
        check("busy_cmd_err", cmd_err, 1);
        drain_read("busy_orig", 2);
        for (int i = 0; i < 3; i++) begin
            check("busy_no_second_burst", rd_valid, 0);
            tick();
        end
        check("busy_rd_count", rd_count, 1);

        // Reset in the middle of a read burst.
        issue(0, 'h10, b10);
        tick();
        check("abort_valid", rd_valid, 1);
        check("abort_word0", sdram_data, sb.pop_front());
        #2 reset_n = 1'b0;
        #1;
        check("abort_rd_valid", rd_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rd_count", rd_count, 0);
        check("abort_cmd_err", cmd_err, 0);
        sb.delete();
        bus_en = 1'b1; bus_d = 32'h5A5A_5A5A;
        #1;
        check("abort_bus_released", sdram_data, 32'h5A5A_5A5A);
        bus_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_rd = 0; exp_wr = 0;
        tick();
        issue(0, 'h10, b10);
        drain_read("abort_reread", 1);
        check("abort_reread_count", rd_count, 1);

        // Backdoor load collides with burst write words 0 and 2.
        set_cmd(1'b1, 1'b1, 'h20);
        bus_en = 1'b1; bus_d = 32'h6000_0000;
        load_en = 1'b1; load_addr = 'h20; load_data = 32'hDEAD_BEEF;
        tick();
        set_cmd(1'b0, 1'b0, '0);
        load_en = 1'b0;
        bus_d = 32'h6000_0001;
        tick();
        bus_d = 32'h6000_0002;
        load_en = 1'b1; load_addr = 'h22; load_data = 32'hCAFE_F00D;
        tick();
        load_en = 1'b0;
        bus_d = 32'h6000_0003;
        tick();
        bus_en = 1'b0;
        check("collide_wr_count", wr_count, 1);
        issue(0, 'h20, mk_burst(32'hDEAD_BEEF, 32'h6000_0001, 32'hCAFE_F00D, 32'h6000_0003));
        drain_read("collide_read", 1);

        // A word loaded during the latency cycle is returned by the first beat.
        issue(0, 'h10, mk_burst(32'h0BAD_CAFE, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333));
        load_en = 1'b1; load_addr = 'h10; load_data = 32'h0BAD_CAFE;
        tick();
        load_en = 1'b0;
        drain_read("raw_read", 2);
        check("final_rd_count", rd_count, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
